operand_fetch: RTL and testbench

Sequencer that sits directly upstream of the 4-input 16-bit source multiplexer and consumes its output. It drives the multiplexer's 2-bit select, captures two 16-bit operands (A then B) from the selected sources, and presents them as a pair to the ALU stage with a valid/ready handshake. When both operands use the same source, a single capture fills both operands.

---
 rtl/operand_fetch.sv | 125 ++++++++++++
 tb/tb_operand_fetch.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// operand_fetch: sequences the 4-input source mux to gather operand A then
// operand B, and hands the captured pair to the ALU stage over valid/ready.
// When both operands name the same source, one capture fills both.
module operand_fetch #(
  parameter int SETTLE_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  src_a,
  input  logic [1:0]  src_b,
  output logic [1:0]  mux_sel,
  input  logic [15:0] mux_value,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic        valid,
  input  logic        ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH_A = 2'd1,
    FETCH_B = 2'd2,
    DONE    = 2'd3
  } state_t;

  // The wait counter runs from 0 up to this value, and the capture happens
  // in the cycle where it has reached it.
  localparam logic [3:0] SettleMax = 4'(SETTLE_CYCLES);

  state_t      state_q;
  logic [1:0]  src_a_q;
  logic [1:0]  src_b_q;
  logic        same_q;
  logic [3:0]  wait_cnt_q;
  logic [15:0] op_a_q;
  logic [15:0] op_b_q;

  logic        accept_d;
  logic        settled_d;

  // A new request is taken from IDLE, or from DONE in the very cycle the
  // current pair is consumed, so back-to-back requests have no bubble.
  assign accept_d  = start && ((state_q == IDLE) || ((state_q == DONE) && ready));
  assign settled_d = (wait_cnt_q == SettleMax);

  // Mux select follows the state; outside a fetch it parks on input 0.
  always_comb begin
    mux_sel = 2'b00;
    case (state_q)
      FETCH_A: mux_sel = src_a_q;
      FETCH_B: mux_sel = src_b_q;
      default: mux_sel = 2'b00;
    endcase
  end

  // Fetch sequencer: request latching, settle counting, operand capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      src_a_q    <= 2'b00;
      src_b_q    <= 2'b00;
      same_q     <= 1'b0;
      wait_cnt_q <= 4'd0;
      op_a_q     <= 16'h0000;
      op_b_q     <= 16'h0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            src_a_q    <= src_a;
            src_b_q    <= src_b;
            same_q     <= (src_a == src_b);
            wait_cnt_q <= 4'd0;
            state_q    <= FETCH_A;
          end
        end
        FETCH_A: begin
          if (!settled_d) begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end else begin
            op_a_q     <= mux_value;
            wait_cnt_q <= 4'd0;
            if (same_q) begin
              op_b_q  <= mux_value;
              state_q <= DONE;
            end else begin
              state_q <= FETCH_B;
            end
          end
        end
        FETCH_B: begin
          if (!settled_d) begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end else begin
            op_b_q     <= mux_value;
            wait_cnt_q <= 4'd0;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (ready) begin
            if (accept_d) begin
              src_a_q    <= src_a;
              src_b_q    <= src_b;
              same_q     <= (src_a == src_b);
              wait_cnt_q <= 4'd0;
              state_q    <= FETCH_A;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign op_a  = op_a_q;
  assign op_b  = op_b_q;
  assign valid = (state_q == DONE);
  assign busy  = (state_q == FETCH_A) || (state_q == FETCH_B);

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: scoreboard bench for operand_fetch. One instance runs with
// no settle cycles, a second with three settle cycles.
module tb_operand_fetch;

  logic        clk;
  logic        reset_n;

  // default-settle instance
  logic        start;
  logic [1:0]  srcA;
  logic [1:0]  srcB;
  logic [1:0]  muxSel;
  logic [15:0] muxValue;
  logic [15:0] opA;
  logic [15:0] opB;
  logic        valid;
  logic        ready;
  logic        busy;
  logic [15:0] muxIn [4];

  // three-settle instance
  logic        start3;
  logic [1:0]  srcA3;
  logic [1:0]  srcB3;
  logic [1:0]  muxSel3;
  logic [15:0] muxValue3;
  logic [15:0] opA3;
  logic [15:0] opB3;
  logic        valid3;
  logic        ready3;
  logic        busy3;
  logic [15:0] muxIn3 [4];

  int          totalCount;
  int          badCount;
  logic [31:0] expQ [$];

  // the mux itself: purely combinational from the select
  assign muxValue  = muxIn[muxSel];
  assign muxValue3 = muxIn3[muxSel3];

  operand_fetch dut0 (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .src_a    (srcA),
    .src_b    (srcB),
    .mux_sel  (muxSel),
    .mux_value(muxValue),
    .op_a     (opA),
    .op_b     (opB),
    .valid    (valid),
    .ready    (ready),
    .busy     (busy)
  );

  operand_fetch #(.SETTLE_CYCLES(3)) dut3 (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start3),
    .src_a    (srcA3),
    .src_b    (srcB3),
    .mux_sel  (muxSel3),
    .mux_value(muxValue3),
    .op_a     (opA3),
    .op_b     (opB3),
    .valid    (valid3),
    .ready    (ready3),
    .busy     (busy3)
  );

  // free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // hard stop in case the sequence never completes
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", totalCount, badCount);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCount++;
    if (got !== exp) begin
      badCount++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // drive the default instance; push the expected pair when the request
  // is one that should be taken
  task automatic applyStimulus(input logic s, input logic [1:0] a, input logic [1:0] b,
                               input logic r, input logic push);
    start = s;
    srcA  = a;
    srcB  = b;
    ready = r;
    if (push) expQ.push_back({muxIn[a], muxIn[b]});
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // pairs are compared when the handshake completes
  always @(negedge clk) begin
    if (reset_n && valid && ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected pair", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        e = expQ.pop_front();
        checkOutput("pair op_a", {16'h0, opA}, {16'h0, e[31:16]});
        checkOutput("pair op_b", {16'h0, opB}, {16'h0, e[15:0]});
      end
    end
  end

  logic [1:0] bbA [5];
  logic [1:0] bbB [5];

  initial begin
    totalCount = 0;
    badCount   = 0;
    reset_n = 1'b0;
    start = 1'b0; srcA = 2'd0; srcB = 2'd0; ready = 1'b0;
    start3 = 1'b0; srcA3 = 2'd0; srcB3 = 2'd0; ready3 = 1'b0;
    muxIn[0] = 16'h1111; muxIn[1] = 16'h2222; muxIn[2] = 16'h3333; muxIn[3] = 16'h4444;
    muxIn3[0] = 16'h5000; muxIn3[1] = 16'h5001; muxIn3[2] = 16'h5002; muxIn3[3] = 16'h5003;

    // reset state
    repeat (2) @(negedge clk);
    checkOutput("reset valid", {31'h0, valid}, 32'd0);
    checkOutput("reset busy", {31'h0, busy}, 32'd0);
    checkOutput("reset mux_sel", {30'h0, muxSel}, 32'd0);
    checkOutput("reset op_a", {16'h0, opA}, 32'd0);
    checkOutput("reset op_b", {16'h0, opB}, 32'd0);
    checkOutput("reset3 valid", {31'h0, valid3}, 32'd0);
    tick();
    reset_n = 1'b1;

    // basic fetch, distinct sources 2 then 1
    applyStimulus(1'b1, 2'd2, 2'd1, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("basic fa mux_sel", {30'h0, muxSel}, 32'd2);
    checkOutput("basic fa busy", {31'h0, busy}, 32'd1);
    checkOutput("basic fa valid", {31'h0, valid}, 32'd0);
    tick();
    @(negedge clk);
    checkOutput("basic fb mux_sel", {30'h0, muxSel}, 32'd1);
    checkOutput("basic fb op_a", {16'h0, opA}, 32'h3333);
    checkOutput("basic fb valid", {31'h0, valid}, 32'd0);
    tick();
    @(negedge clk);
    checkOutput("basic done valid", {31'h0, valid}, 32'd1);
    checkOutput("basic done mux_sel", {30'h0, muxSel}, 32'd0);
    tick();
    @(negedge clk);
    checkOutput("basic idle valid", {31'h0, valid}, 32'd0);
    checkOutput("basic idle busy", {31'h0, busy}, 32'd0);

    // same source: a single capture fills both operands
    muxIn[3] = 16'hBEEF;
    tick();
    applyStimulus(1'b1, 2'd3, 2'd3, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("same fa mux_sel", {30'h0, muxSel}, 32'd3);
    checkOutput("same fa valid", {31'h0, valid}, 32'd0);
    tick();
    @(negedge clk);
    checkOutput("same done valid", {31'h0, valid}, 32'd1);
    checkOutput("same op_a", {16'h0, opA}, 32'hBEEF);
    checkOutput("same op_b", {16'h0, opB}, 32'hBEEF);
    tick();
    @(negedge clk);
    checkOutput("same idle valid", {31'h0, valid}, 32'd0);

    // backpressure: pair held, inputs and start pulses must not disturb it
    muxIn[0] = 16'h1111; muxIn[2] = 16'h3333;
    applyStimulus(1'b1, 2'd0, 2'd2, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    tick();
    tick();
    @(negedge clk);
    checkOutput("bp first valid", {31'h0, valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      for (int k = 0; k < 4; k++) muxIn[k] = 16'($urandom);
      applyStimulus(i[0] ? 1'b0 : 1'b1, 2'd1, 2'd1, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("bp valid held", {31'h0, valid}, 32'd1);
      checkOutput("bp op_a held", {16'h0, opA}, 32'h1111);
      checkOutput("bp op_b held", {16'h0, opB}, 32'h3333);
    end
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
    tick();
    @(negedge clk);
    checkOutput("bp idle valid", {31'h0, valid}, 32'd0);
    checkOutput("bp idle busy", {31'h0, busy}, 32'd0);

    // back-to-back: start held, requests alternate (0,3) and (1,2)
    muxIn[0] = 16'hA000; muxIn[1] = 16'hA001; muxIn[2] = 16'hA002; muxIn[3] = 16'hA003;
    for (int i = 0; i < 5; i++) begin
      bbA[i] = i[0] ? 2'd1 : 2'd0;
      bbB[i] = i[0] ? 2'd2 : 2'd3;
    end
    tick();
    applyStimulus(1'b1, bbA[0], bbB[0], 1'b1, 1'b1);
    tick();
    for (int i = 1; i <= 4; i++) begin
      if (i < 4) applyStimulus(1'b1, bbA[i], bbB[i], 1'b1, 1'b1);
      else applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("b2b fa valid", {31'h0, valid}, 32'd0);
      checkOutput("b2b fa mux_sel", {30'h0, muxSel}, {30'h0, bbA[i-1]});
      tick();
      @(negedge clk);
      checkOutput("b2b fb valid", {31'h0, valid}, 32'd0);
      checkOutput("b2b fb mux_sel", {30'h0, muxSel}, {30'h0, bbB[i-1]});
      tick();
      @(negedge clk);
      checkOutput("b2b done valid", {31'h0, valid}, 32'd1);
      tick();
    end
    @(negedge clk);
    checkOutput("b2b end valid", {31'h0, valid}, 32'd0);
    checkOutput("b2b end busy", {31'h0, busy}, 32'd0);

    // reset mid FETCH_B with op_a already captured
    muxIn[0] = 16'h1234; muxIn[1] = 16'h5678;
    tick();
    applyStimulus(1'b1, 2'd0, 2'd1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
    tick();
    @(negedge clk);
    checkOutput("rst pre op_a", {16'h0, opA}, 32'h1234);
    checkOutput("rst pre busy", {31'h0, busy}, 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("rst valid", {31'h0, valid}, 32'd0);
    checkOutput("rst busy", {31'h0, busy}, 32'd0);
    checkOutput("rst mux_sel", {30'h0, muxSel}, 32'd0);
    checkOutput("rst op_a", {16'h0, opA}, 32'd0);
    checkOutput("rst op_b", {16'h0, opB}, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("rst after valid", {31'h0, valid}, 32'd0);
      tick();
    end

    // settle: three wait cycles, the value changes after the select switches
    start3 = 1'b1; srcA3 = 2'd0; srcB3 = 2'd1; ready3 = 1'b1;
    tick();
    start3 = 1'b0;
    @(negedge clk);
    checkOutput("settle fa mux_sel", {30'h0, muxSel3}, 32'd0);
    checkOutput("settle fa busy", {31'h0, busy3}, 32'd1);
    for (int j = 1; j <= 9; j++) begin
      tick();
      if (j == 1) muxIn3[0] = 16'hC0DE;
      if (j == 5) muxIn3[1] = 16'hF00D;
      @(negedge clk);
      if (j < 4) begin
        checkOutput("settle a wait op_a", {16'h0, opA3}, 32'd0);
        checkOutput("settle a wait mux_sel", {30'h0, muxSel3}, 32'd0);
        checkOutput("settle a wait busy", {31'h0, busy3}, 32'd1);
      end else if (j == 4) begin
        checkOutput("settle a cap op_a", {16'h0, opA3}, 32'hC0DE);
        checkOutput("settle b mux_sel", {30'h0, muxSel3}, 32'd1);
        checkOutput("settle b op_b", {16'h0, opB3}, 32'd0);
      end else if (j < 8) begin
        checkOutput("settle b wait valid", {31'h0, valid3}, 32'd0);
        checkOutput("settle b wait op_b", {16'h0, opB3}, 32'd0);
      end else if (j == 8) begin
        checkOutput("settle valid", {31'h0, valid3}, 32'd1);
        checkOutput("settle op_a", {16'h0, opA3}, 32'hC0DE);
        checkOutput("settle op_b", {16'h0, opB3}, 32'hF00D);
      end else begin
        checkOutput("settle idle valid", {31'h0, valid3}, 32'd0);
        checkOutput("settle idle busy", {31'h0, busy3}, 32'd0);
      end
    end

    checkOutput("scoreboard drained", expQ.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
